// File: rtl/pixel_arbiter_pkg.sv
// Frame-buffer geometry and arbitration types shared by the pixel arbiter files.
package pixel_arbiter_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int PIX_COUNT = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 19;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_VGA,
    GNT_RD,
    GNT_WR
  } grant_e;
endpackage

// File: rtl/pixel_arbiter_if.sv
// Bundle of the VGA, CPU and frame-buffer signals seen by the pixel arbiter.
interface pixel_arbiter_if #(
  parameter int ADDR_W = pixel_arbiter_pkg::ADDR_W
);
  // CPU handshake: a request (cpu_we or cpu_re) is taken on a rising edge only when
  // cpu_ready is high in that cycle; the requester holds it until then. Read data
  // returns later as a one-cycle cpu_rvalid pulse. VGA reads are never back-pressured.
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_pixel;
  logic              cpu_we;
  logic              cpu_re;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_din;
  logic              cpu_ready;
  logic              cpu_dout;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_din;
  logic              mem_dout;

  modport slave (
    input  vga_req, vga_addr, cpu_we, cpu_re, cpu_addr, cpu_din, mem_dout,
    output vga_pixel, cpu_ready, cpu_dout, cpu_rvalid, mem_addr, mem_we, mem_din
  );

  modport master (
    output vga_req, vga_addr, cpu_we, cpu_re, cpu_addr, cpu_din, mem_dout,
    input  vga_pixel, cpu_ready, cpu_dout, cpu_rvalid, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/pixel_arbiter_wq.sv
// Synchronous FIFO holding CPU pixel writes until the frame buffer is free.
module pixel_wq
  import pixel_arbiter_pkg::*;
#(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Flags come from registered count only, so a same-cycle pop never makes room
  // for a push and a same-cycle push is never visible to the pop side.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/pixel_arbiter.sv
// Shares one single-port frame buffer between the VGA scan-out and the CPU pixel port.
module pixel_arbiter
  import pixel_arbiter_pkg::*;
#(
  parameter int ADDR_W    = pixel_arbiter_pkg::ADDR_W,
  parameter int PIX_COUNT = pixel_arbiter_pkg::PIX_COUNT,
  parameter int WQ_DEPTH  = 4
) (
  input  logic           clock,
  input  logic           resetn,
  pixel_arbiter_if.slave bus
);
  localparam int WQ_W  = ADDR_W + 1;
  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
  localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W+1)'(PIX_COUNT);

  grant_e            grant;
  logic              addr_oob, wr_acc, rd_acc;
  logic              wq_push, wq_pop, wq_full, wq_empty;
  logic [WQ_W-1:0]   wq_head;
  logic [CNT_W-1:0]  wq_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_din, vga_pixel;

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              rd_inflight_q, oob_rvalid_q, vga_inflight_q, vga_hold_q;
  logic [ADDR_W-1:0] last_addr_q;

  pixel_wq #(.W(WQ_W), .DEPTH(WQ_DEPTH)) u_wq (
    .clock_i  (clock),
    .resetn_i (resetn),
    .push_i   (wq_push),
    .pop_i    (wq_pop),
    .din_i    ({bus.cpu_addr, bus.cpu_din}),
    .dout_o   (wq_head),
    .full_o   (wq_full),
    .empty_o  (wq_empty),
    .count_o  (wq_count)
  );

  assign addr_oob = ({1'b0, bus.cpu_addr} >= PIX_LIMIT);

  // Reads wait for an empty queue so they always observe every earlier write.
  assign wr_acc = resetn & bus.cpu_we & ~wq_full;
  assign rd_acc = resetn & bus.cpu_re & ~bus.cpu_we & ~pend_q & (wq_count == '0);
  assign wq_push = wr_acc & ~addr_oob;
  assign wq_pop  = (grant == GNT_WR);

  always_comb begin
    grant = GNT_IDLE;
    if (resetn) begin
      if (bus.vga_req)    grant = GNT_VGA;
      else if (pend_q)    grant = GNT_RD;
      else if (!wq_empty) grant = GNT_WR;
    end
  end

  always_comb begin
    mem_addr = last_addr_q;
    mem_we   = 1'b0;
    mem_din  = 1'b0;
    case (grant)
      GNT_VGA: mem_addr = bus.vga_addr;
      GNT_RD:  mem_addr = pend_addr_q;
      GNT_WR: begin
        mem_addr = wq_head[WQ_W-1:1];
        mem_we   = 1'b1;
        mem_din  = wq_head[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (rd_acc && !addr_oob) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.cpu_addr;
    end else if (grant == GNT_RD) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend_q         <= 1'b0;
      pend_addr_q    <= '0;
      rd_inflight_q  <= 1'b0;
      oob_rvalid_q   <= 1'b0;
      vga_inflight_q <= 1'b0;
      vga_hold_q     <= 1'b0;
      last_addr_q    <= '0;
    end else begin
      pend_q         <= pend_d;
      pend_addr_q    <= pend_addr_d;
      rd_inflight_q  <= (grant == GNT_RD);
      oob_rvalid_q   <= rd_acc & addr_oob;
      vga_inflight_q <= (grant == GNT_VGA);
      vga_hold_q     <= vga_pixel;
      last_addr_q    <= mem_addr;
    end
  end

  // Memory data is already one cycle late, so returns steer it straight through.
  assign vga_pixel      = vga_inflight_q ? bus.mem_dout : vga_hold_q;
  assign bus.vga_pixel  = vga_pixel;
  assign bus.cpu_ready  = wr_acc | rd_acc;
  assign bus.cpu_rvalid = resetn & (rd_inflight_q | oob_rvalid_q);
  assign bus.cpu_dout   = resetn & rd_inflight_q & bus.mem_dout;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_we     = mem_we;
  assign bus.mem_din    = mem_din;
endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, frame-buffer pixel address width.
REQ-002 SHALL have parameter PIX_COUNT, default 307200, number of valid pixels (640x480).
REQ-003 SHALL have parameter WQ_DEPTH, default 4, CPU write-queue depth (power of two, >=2).
REQ-004 SHALL have port clock  in  1  the single clock; every flop updates on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port vga_req  in  1  VGA read request, issued this cycle.
REQ-007 SHALL have port vga_addr  in  ADDR_W  VGA read address.
REQ-008 SHALL have port vga_pixel  out  1  VGA read data, valid one cycle after vga_req.
REQ-009 SHALL have port cpu_we  in  1  CPU pixel-write request (pixelWe).
REQ-010 SHALL have port cpu_re  in  1  CPU pixel-read request.
REQ-011 SHALL have port cpu_addr  in  ADDR_W  CPU pixel address.
REQ-012 SHALL have port cpu_din  in  1  CPU write data.
REQ-013 SHALL have port cpu_ready  out  1  request accepted this cycle when high.
REQ-014 SHALL have port cpu_dout  out  1  CPU read data, valid when cpu_rvalid high.
REQ-015 SHALL have port cpu_rvalid  out  1  one-cycle pulse marking cpu_dout valid.
REQ-016 SHALL have port mem_addr  out  ADDR_W  frame-buffer address.
REQ-017 SHALL have port mem_we  out  1  frame-buffer write enable.
REQ-018 SHALL have port mem_din  out  1  frame-buffer write data.
REQ-019 SHALL have port mem_dout  in  1  frame-buffer read data, synchronous, 1-cycle latency.

Function
REQ-020 Grant per cycle, fixed priority: VGA read > CPU read (pending) > write-queue head > idle.
REQ-021 VGA: mem_addr=vga_addr, mem_we=0; vga_pixel=mem_dout on the next cycle; never stalled.
REQ-022 cpu_we accepted (cpu_ready=1) iff queue not full; entry {addr,din} pushed the same edge.
REQ-023 Write with cpu_addr >= PIX_COUNT: accepted, not queued, never reaches memory.
REQ-024 cpu_re accepted iff no CPU read pending and queue empty (read-after-write order); else cpu_ready=0.
REQ-025 Accepted read held in pending register until granted; cpu_rvalid pulses one cycle after grant, cpu_dout=mem_dout.
REQ-026 Read with cpu_addr >= PIX_COUNT: cpu_rvalid next cycle, cpu_dout=0, no memory access.
REQ-027 cpu_we and cpu_re both high: write takes precedence, read not accepted.
REQ-028 Queue push and pop same cycle when full: pop frees slot only next cycle (no bypass); when empty, push not popped same cycle.
REQ-029 Queue pointers wrap modulo WQ_DEPTH; count 0..WQ_DEPTH.
REQ-030 Idle cycle: mem_we=0, mem_addr holds last value, mem_din=0.
REQ-031 vga_pixel holds last value in cycles following no VGA grant.

Reset
REQ-032 resetn=0 at a rising edge: queue emptied, pending read dropped, cpu_rvalid=0, cpu_dout=0, vga_pixel=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-033 cpu_ready=0 while resetn=0; requests in reset cycles ignored; in-flight reads dropped with no cpu_rvalid.

Structure
REQ-034 Shared package SHALL hold FB_WIDTH=640, FB_HEIGHT=480, PIX_COUNT and ADDR_W constants.
REQ-035 Write queue SHALL be one sub-module, pixel_wq (sync FIFO, full/empty/count outputs).
REQ-036 Arbiter grant logic combinational from registered state; all outputs to memory registered-free, data returns registered.

Verification
REQ-037 Reset: hold resetn=0 2 cycles with cpu_we=1 -> queue empty, cpu_ready=0, mem_we=0 throughout.
REQ-038 4 writes addr 0..3 din=1 while vga_req=1 -> cpu_ready 1,1,1,1 then 0 on 5th; no mem_we until vga_req drops; then 4 writes in order.
REQ-039 Write addr 10 din=1, then cpu_re addr 10 -> read stalled until write drained; cpu_dout=1 with single cpu_rvalid.
REQ-040 cpu_we addr 307200 -> accepted, mem_we never asserted; cpu_re addr 400000 -> cpu_rvalid next cycle, cpu_dout=0.
REQ-041 Pending read addr 5, resetn pulsed low 1 cycle -> no cpu_rvalid; next vga_req addr 7 returns mem contents next cycle.
REQ-042 Continuous vga_req 800 cycles then 160 idle, CPU writing every cycle -> no VGA stall, all accepted writes reach memory.
